// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roller and the display_logic stage
// that consumes die values.
package dice_pkg;

  localparam logic [2:0] DIE_MIN = 3'd1;
  localparam logic [2:0] DIE_MAX = 3'd6;

  typedef logic [2:0] die_t;

  typedef enum logic {
    IDLE    = 1'b0,
    ROLLING = 1'b1
  } roll_state_t;

  // Next face of a spinning die: 1 -> 2 -> ... -> 6 -> 1.
  function automatic die_t next_face(input die_t face);
    return (face >= DIE_MAX) ? DIE_MIN : die_t'(face + 3'd1);
  endfunction

endpackage

// File: rtl/dice_channel.sv
// One player channel: button synchroniser, debouncer, roll FSM and the mod-6
// spin counter whose value is captured onto the die when the button is released.
module dice_channel
  import dice_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DB_W            = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output die_t dice,
  output logic rolled,
  output logic rolling
);

  // The level flips on the sample that completes the run, so compare
  // against the count of samples already seen before it.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        db_level_q, db_level_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic        db_rise, db_fall;
  roll_state_t state_q, state_d;
  die_t        spin_q, spin_d;
  die_t        dice_q, dice_d;
  logic        rolled_q, rolled_d;

  // Two-stage synchroniser feeding the raw button into the clock domain.
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
  end

  // Debouncer: a level change is accepted only after an unbroken run of
  // differing samples; any agreeing sample restarts the run.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    db_rise    = 1'b0;
    db_fall    = 1'b0;
    if (sync2_q != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = ~db_level_q;
        db_rise    = sync2_q;
        db_fall    = ~sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Roll FSM: spin while held, capture the current spin value on release.
  always_comb begin
    state_d  = state_q;
    spin_d   = spin_q;
    dice_d   = dice_q;
    rolled_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (db_rise) begin
          state_d = ROLLING;
        end
      end
      ROLLING: begin
        if (db_fall) begin
          state_d  = IDLE;
          dice_d   = spin_q;
          rolled_d = 1'b1;
        end else begin
          spin_d = next_face(spin_q);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
      state_q    <= IDLE;
      spin_q     <= DIE_MIN;
      dice_q     <= DIE_MIN;
      rolled_q   <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      spin_q     <= spin_d;
      dice_q     <= dice_d;
      rolled_q   <= rolled_d;
    end
  end

  assign dice    = dice_q;
  assign rolled  = rolled_q;
  assign rolling = (state_q == ROLLING);

endmodule

// File: rtl/dice_roller.sv
// Two independent player dice channels feeding display_logic.
module dice_roller
  import dice_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DB_W            = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn1,
  input  logic btn2,
  output die_t dice1,
  output die_t dice2,
  output logic rolled1,
  output logic rolled2,
  output logic rolling1,
  output logic rolling2
);

  dice_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W           (DB_W)
  ) u_ch1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn    (btn1),
    .dice   (dice1),
    .rolled (rolled1),
    .rolling(rolling1)
  );

  dice_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W           (DB_W)
  ) u_ch2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn    (btn2),
    .dice   (dice2),
    .rolled (rolled2),
    .rolling(rolling2)
  );

endmodule

// File: tb/tb_dice_roller.sv
// Bench for dice_roller with a short debounce window; a history-based model
// predicts every output each cycle, plus literal die values for each scenario.
module tb_dice_roller;

  localparam int DB_N = 4;
  localparam int HIST = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn1 = 1'b0;
  logic       btn2 = 1'b0;
  logic [2:0] dice1, dice2;
  logic       rolled1, rolled2, rolling1, rolling2;

  int n_cmp = 0;
  int n_fail = 0;

  // Model state: raw button history per channel plus per-roll bookkeeping.
  bit raw [2][HIST];
  int cyc = 0;
  int base = 1;
  int mark [2] = '{0, 0};
  bit m_lvl [2] = '{1'b0, 1'b0};
  int m_spin [2] = '{1, 1};
  int m_dice [2] = '{1, 1};
  bit m_rolled [2] = '{1'b0, 1'b0};
  int m_start [2] = '{0, 0};
  int m_s [2] = '{1, 1};

  // Observation counters maintained by the compare process.
  int rolled_cnt [2] = '{0, 0};
  int rise_cnt [2] = '{0, 0};
  int both_cnt = 0;

  dice_roller #(.DEBOUNCE_CYCLES(DB_N), .DB_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn1    (btn1),
    .btn2    (btn2),
    .dice1   (dice1),
    .dice2   (dice2),
    .rolled1 (rolled1),
    .rolled2 (rolled2),
    .rolling1(rolling1),
    .rolling2(rolling2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit b1, input bit b2, input int cycles);
    btn1 = b1;
    btn2 = b2;
    repeat (cycles) @(negedge clk);
  endtask

  // What the synchronised button looked like at edge t (zero before reset release).
  function automatic bit synced(input int c, input int t);
    if (t - 2 < base) return 1'b0;
    return raw[c][(t - 2) % HIST];
  endfunction

  function automatic void model_reset();
    base = cyc + 1;
    for (int c = 0; c < 2; c++) begin
      mark[c] = cyc;
      m_lvl[c] = 1'b0;
      m_spin[c] = 1;
      m_dice[c] = 1;
      m_rolled[c] = 1'b0;
    end
  endfunction

  // Behavioural model: a press/release is accepted after DB_N agreeing synced
  // samples; the die reflects how long the roll lasted from its starting face.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        cyc++;
        for (int c = 0; c < 2; c++) begin
          bit accept;
          raw[c][cyc % HIST] = (c == 0) ? btn1 : btn2;
          m_rolled[c] = 1'b0;
          accept = (cyc - mark[c] >= DB_N);
          for (int k = 0; k < DB_N; k++) begin
            if (synced(c, cyc - k) == m_lvl[c]) accept = 1'b0;
          end
          if (accept) begin
            m_lvl[c] = ~m_lvl[c];
            mark[c] = cyc;
            if (m_lvl[c]) begin
              m_start[c] = cyc;
              m_s[c] = m_spin[c];
            end else begin
              m_dice[c] = ((m_s[c] - 1 + (cyc - m_start[c]) - 1) % 6) + 1;
              m_spin[c] = m_dice[c];
              m_rolled[c] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Compare every output against the model once per cycle, away from the edge.
  initial begin
    bit prev_rolling [2];
    prev_rolling = '{1'b0, 1'b0};
    forever begin
      @(negedge clk);
      checkOutput("dice1", dice1, m_dice[0]);
      checkOutput("dice2", dice2, m_dice[1]);
      checkOutput("rolled1", rolled1, m_rolled[0]);
      checkOutput("rolled2", rolled2, m_rolled[1]);
      checkOutput("rolling1", rolling1, m_lvl[0]);
      checkOutput("rolling2", rolling2, m_lvl[1]);
      if (rolled1) rolled_cnt[0]++;
      if (rolled2) rolled_cnt[1]++;
      if (rolled1 && rolled2) both_cnt++;
      if (rolling1 && !prev_rolling[0]) rise_cnt[0]++;
      if (rolling2 && !prev_rolling[1]) rise_cnt[1]++;
      prev_rolling[0] = rolling1;
      prev_rolling[1] = rolling2;
    end
  end

  // Watchdog so a stuck run still reports.
  initial begin
    #100000;
    n_fail++;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Directed scenarios with hand-computed die values.
  initial begin
    int r0, r1, s0, s1, b0;

    repeat (3) @(negedge clk);
    checkOutput("reset_dice1", dice1, 1);
    checkOutput("reset_dice2", dice2, 1);
    checkOutput("reset_rolling1", rolling1, 0);
    checkOutput("reset_rolled1", rolled1, 0);
    rst_n = 1'b1;

    // Short pulse must be rejected.
    r0 = rolled_cnt[0]; s0 = rise_cnt[0];
    applyStimulus(1, 0, 3);
    applyStimulus(0, 0, 8);
    checkOutput("glitch_dice1", dice1, 1);
    checkOutput("glitch_rolled1", rolled_cnt[0] - r0, 0);
    checkOutput("glitch_rise1", rise_cnt[0] - s0, 0);

    // Four rolling cycles from 1 -> 4, then four more from 4 -> 1.
    r0 = rolled_cnt[0];
    applyStimulus(1, 0, 4);
    applyStimulus(0, 0, 8);
    checkOutput("roll_a_dice1", dice1, 4);
    checkOutput("roll_a_pulses1", rolled_cnt[0] - r0, 1);
    applyStimulus(1, 0, 4);
    applyStimulus(0, 0, 8);
    checkOutput("roll_b_dice1", dice1, 1);

    // Simultaneous six-cycle rolls on both channels.
    b0 = both_cnt; r0 = rolled_cnt[0]; r1 = rolled_cnt[1];
    applyStimulus(1, 1, 6);
    applyStimulus(0, 0, 8);
    checkOutput("both_dice1", dice1, 6);
    checkOutput("both_dice2", dice2, 6);
    checkOutput("both_coincide", both_cnt - b0, 1);
    checkOutput("both_pulses1", rolled_cnt[0] - r0, 1);
    checkOutput("both_pulses2", rolled_cnt[1] - r1, 1);

    // Channel 2 alone, nine cycles from 6 -> 2; channel 1 untouched.
    r0 = rolled_cnt[0];
    applyStimulus(0, 1, 9);
    applyStimulus(0, 0, 8);
    checkOutput("solo_dice2", dice2, 2);
    checkOutput("solo_dice1", dice1, 6);
    checkOutput("solo_rolled1", rolled_cnt[0] - r0, 0);

    // Reset while channel 1 is rolling, button kept held through reset.
    r0 = rolled_cnt[0];
    applyStimulus(1, 0, 6);
    checkOutput("pre_reset_rolling1", rolling1, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_dice1", dice1, 1);
    checkOutput("async_dice2", dice2, 1);
    checkOutput("async_rolling1", rolling1, 0);
    checkOutput("async_rolled1", rolled1, 0);
    repeat (2) @(negedge clk);
    checkOutput("reset_nopulse1", rolled_cnt[0] - r0, 0);
    rst_n = 1'b1;
    r0 = rolled_cnt[0];
    applyStimulus(1, 0, 5);
    applyStimulus(0, 0, 8);
    checkOutput("held_dice1", dice1, 5);
    checkOutput("held_pulses1", rolled_cnt[0] - r0, 1);

    // Bouncy press on channel 2, then a clean six-cycle hold from 1 -> 6.
    r1 = rolled_cnt[1]; s1 = rise_cnt[1];
    for (int i = 0; i < 10; i++) applyStimulus(0, (i % 2) == 0, 1);
    applyStimulus(0, 1, 6);
    applyStimulus(0, 0, 8);
    checkOutput("bounce_dice2", dice2, 6);
    checkOutput("bounce_pulses2", rolled_cnt[1] - r1, 1);
    checkOutput("bounce_rises2", rise_cnt[1] - s1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
